// File: rtl/tlc_ped_ctrl.sv
// Pedestrian crossing controller slaved to the vehicle lamps of tlc_top.
// Grants WALK then flashing DON'T WALK on a red rise once a debounced press is registered.
module tlc_ped_ctrl #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int WALK_CYC     = 10,
    parameter int FLASH_CYC    = 8,
    parameter int BLINK_HALF   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic       ped_btn,
    output logic       walk,
    output logic       dont_walk,
    output logic       ped_wait,
    output logic [4:0] countdown,
    output logic       ped_abort
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_FLASH = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [4:0] DEB_SAT    = 5'(DEBOUNCE_CYC);
    localparam logic [4:0] DEB_LAST   = 5'(DEBOUNCE_CYC - 1);
    localparam logic [4:0] WALK_LOAD  = 5'(WALK_CYC - 1);
    localparam logic [4:0] FLASH_LOAD = 5'(FLASH_CYC - 1);
    localparam logic [3:0] BLINK_LAST = 4'(BLINK_HALF - 1);

    logic       sync1_q, sync2_q;
    logic [4:0] deb_q;
    logic       red_d_q;
    state_t     state_q;
    logic       req_q;
    logic [4:0] cnt_q;
    logic [3:0] blink_q;
    logic       walk_q, dont_walk_q, abort_q;

    logic accept, red_rise, one_hot, red_only;

    // Counter saturates one past the acceptance value, so a held button accepts once.
    assign accept   = sync2_q && (deb_q == DEB_LAST);
    assign red_rise = red & ~red_d_q;
    assign one_hot  = (red & ~yellow & ~green) | (~red & yellow & ~green) | (~red & ~yellow & green);
    assign red_only = red & ~yellow & ~green;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= '0;
            red_d_q <= 1'b0;
        end else begin
            sync1_q <= ped_btn;
            sync2_q <= sync1_q;
            red_d_q <= red;
            if (!sync2_q) begin
                deb_q <= '0;
            end else if (deb_q != DEB_SAT) begin
                deb_q <= deb_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b0;
            cnt_q       <= '0;
            blink_q     <= '0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            abort_q     <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (red_rise && one_hot && (req_q || accept)) begin
                        state_q     <= S_WALK;
                        cnt_q       <= WALK_LOAD;
                        walk_q      <= 1'b1;
                        dont_walk_q <= 1'b0;
                        req_q       <= 1'b0;
                    end else if (accept) begin
                        req_q <= 1'b1;
                    end
                end
                S_WALK, S_FLASH: begin
                    if (!red_only) begin
                        state_q     <= S_IDLE;
                        cnt_q       <= '0;
                        walk_q      <= 1'b0;
                        dont_walk_q <= 1'b1;
                        abort_q     <= 1'b1;
                    end else if (cnt_q == 5'd0) begin
                        state_q     <= (state_q == S_WALK) ? S_FLASH : S_HOLD;
                        cnt_q       <= (state_q == S_WALK) ? FLASH_LOAD : 5'd0;
                        blink_q     <= '0;
                        walk_q      <= 1'b0;
                        dont_walk_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                        // Blink phase only advances while flashing.
                        if (state_q == S_FLASH) begin
                            if (blink_q == BLINK_LAST) begin
                                blink_q     <= '0;
                                dont_walk_q <= ~dont_walk_q;
                            end else begin
                                blink_q <= blink_q + 4'd1;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        req_q <= 1'b1;
                    end
                    if (!red) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    walk_q      <= 1'b0;
                    dont_walk_q <= 1'b1;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign walk      = walk_q;
    assign dont_walk = dont_walk_q;
    assign ped_wait  = req_q;
    assign countdown = cnt_q;
    assign ped_abort = abort_q;

endmodule

// File: tb/tb_tlc_ped_ctrl.sv
// Self-checking bench for tlc_ped_ctrl: vector table, directed corner sequences,
// and randomized vehicle/button traffic against a phase-and-elapsed-time model.
module tb_tlc_ped_ctrl;

    localparam int DEB = 4;
    localparam int WC  = 10;
    localparam int FC  = 8;
    localparam int BH  = 2;

    localparam int P_IDLE  = 0;
    localparam int P_WALK  = 1;
    localparam int P_FLASH = 2;
    localparam int P_HOLD  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       red = 1'b0, yellow = 1'b0, green = 1'b1, ped_btn = 1'b0;
    logic       walk, dont_walk, ped_wait, ped_abort;
    logic [4:0] countdown;

    int checks   = 0;
    int failures = 0;

    tlc_ped_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .WALK_CYC    (WC),
        .FLASH_CYC   (FC),
        .BLINK_HALF  (BH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .red      (red),
        .yellow   (yellow),
        .green    (green),
        .ped_btn  (ped_btn),
        .walk     (walk),
        .dont_walk(dont_walk),
        .ped_wait (ped_wait),
        .countdown(countdown),
        .ped_abort(ped_abort)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       btn, r, y, g;
        logic       w, dw, pw;
        logic [4:0] cd;
        logic       ab;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [8:0] pk(input logic w, input logic dw, input logic pw,
                                      input logic [4:0] cd, input logic ab);
        return {w, dw, pw, cd, ab};
    endfunction

    task automatic chk(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = {walk, dont_walk, ped_wait, countdown, ped_abort};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got w=%0b dw=%0b pw=%0b cd=%0d ab=%0b, want w=%0b dw=%0b pw=%0b cd=%0d ab=%0b",
                     name, act[8], act[7], act[6], act[5:1], act[0],
                     exp[8], exp[7], exp[6], exp[5:1], exp[0]);
        end
    endtask

    // Inputs change at the falling edge; outputs are read at the next falling edge.
    task automatic cyc(input logic b, input logic r, input logic y, input logic g);
        ped_btn = b; red = r; yellow = y; green = g;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; ped_btn = 1'b0; red = 1'b0; yellow = 1'b0; green = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic add(input logic btn, input logic r, input logic y, input logic g,
                       input logic w, input logic dw, input logic pw, input int cd);
        vec_t v;
        v.btn = btn; v.r = r; v.y = y; v.g = g;
        v.w = w; v.dw = dw; v.pw = pw; v.cd = 5'(cd); v.ab = 1'b0;
        tbl.push_back(v);
    endtask

    // Accepted press during green, then red rise; leaves the DUT showing walk, countdown 9.
    task automatic press_then_red(input string tag);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk({tag, "_walk_entry"}, pk(1, 0, 0, 9, 0));
    endtask

    // Reference model: crossing phase plus cycles elapsed within it.
    bit m_q[$];
    int m_run, m_phase, m_el;
    bit m_red_prev, m_req, m_abort;

    task automatic m_reset();
        m_q.delete(); m_q.push_back(1'b0); m_q.push_back(1'b0);
        m_run = 0; m_phase = P_IDLE; m_el = 0;
        m_red_prev = 1'b0; m_req = 1'b0; m_abort = 1'b0;
    endtask

    task automatic m_step(input bit btn, input bit r, input bit y, input bit g);
        bit s, acc, rise, oneh, legal;
        s = m_q.pop_front();
        m_q.push_back(btn);
        m_run = s ? m_run + 1 : 0;
        acc   = s && (m_run == DEB);
        rise  = r && !m_red_prev;
        m_red_prev = r;
        oneh  = (int'(r) + int'(y) + int'(g)) == 1;
        legal = r && oneh;
        m_abort = 1'b0;
        case (m_phase)
            P_IDLE: begin
                if (rise && oneh && (m_req || acc)) begin
                    m_phase = P_WALK; m_el = 0; m_req = 1'b0;
                end else if (acc) m_req = 1'b1;
            end
            P_WALK, P_FLASH: begin
                if (!legal) begin
                    m_phase = P_IDLE; m_abort = 1'b1;
                end else if (m_el == ((m_phase == P_WALK) ? WC : FC) - 1) begin
                    m_phase = (m_phase == P_WALK) ? P_FLASH : P_HOLD; m_el = 0;
                end else m_el++;
            end
            default: begin
                if (acc) m_req = 1'b1;
                if (!r) m_phase = P_IDLE;
            end
        endcase
    endtask

    function automatic logic [8:0] m_exp();
        logic w, dw;
        int   cd;
        w  = (m_phase == P_WALK);
        cd = (m_phase == P_WALK) ? WC - 1 - m_el : (m_phase == P_FLASH) ? FC - 1 - m_el : 0;
        dw = (m_phase == P_WALK) ? 1'b0 :
             (m_phase == P_FLASH) ? (((m_el / BH) % 2) == 0) : 1'b1;
        return pk(w, dw, m_req, 5'(cd), m_abort);
    endfunction

    initial begin
        logic [7:0] flash_pat;
        logic [2:0] lam;
        logic [2:0] bad [5];
        int vph, vleft, bleft, walks;
        bit bon;

        flash_pat = 8'b1100_1100;
        bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

        for (int i = 0; i < 10; i++) add(i < 6, 0, 0, 1, 0, 1, i >= 5, 0);
        add(0, 0, 1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 1, 0, 0, 9 - i);
        for (int k = 0; k < 8; k++) add(0, 1, 0, 0, 0, flash_pat[7 - k], 0, 7 - k);
        add(0, 1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0);

        @(negedge clk);
        do_reset();
        chk("reset_state", pk(0, 1, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].btn, tbl[i].r, tbl[i].y, tbl[i].g);
            chk($sformatf("vec%0d", i), pk(tbl[i].w, tbl[i].dw, tbl[i].pw, tbl[i].cd, tbl[i].ab));
            $display("vec %0d: btn=%0b ryg=%0b%0b%0b -> w=%0b dw=%0b pw=%0b cd=%0d ab=%0b",
                     i, tbl[i].btn, tbl[i].r, tbl[i].y, tbl[i].g,
                     walk, dont_walk, ped_wait, countdown, ped_abort);
        end

        // Short press below the debounce length must never register.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("short_press_no_wait", pk(0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("short_press_red%0d", i), pk(0, 1, 0, 0, 0));
        end
        $display("seq short_press: done");

        // Red drops three cycles into WALK.
        do_reset();
        press_then_red("walk_abort");
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("walk_abort_cd7", pk(1, 0, 0, 7, 0));
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("walk_abort_pulse", pk(0, 1, 0, 0, 1));
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("walk_abort_after", pk(0, 1, 0, 0, 0));
        $display("seq walk_abort: done");

        // Red and yellow together during FLASH.
        do_reset();
        press_then_red("flash_abort");
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("flash_abort_cd6", pk(0, 1, 0, 6, 0));
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("flash_abort_pulse", pk(0, 1, 0, 0, 1));
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("flash_abort_idle", pk(0, 1, 0, 0, 0));
        $display("seq flash_abort: done");

        // Asynchronous reset in the middle of WALK, then red already high at release.
        do_reset();
        press_then_red("async_rst");
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("async_rst_cd8", pk(1, 0, 0, 8, 0));
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_rst_immediate", pk(0, 1, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("async_rst_red%0d", i), pk(0, 1, 0, 0, 0));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("async_rst_rerise%0d", i), pk(0, 1, 0, 0, 0));
        end
        $display("seq async_rst: done");

        // Randomized vehicle cycles, button presses and lamp glitches.
        do_reset();
        m_reset();
        vph = 0; vleft = 6; bleft = 3; bon = 1'b0; walks = 0;
        for (int c = 0; c < 4000; c++) begin
            if (vleft == 0) begin
                vph = (vph + 1) % 3;
                if (vph == 0) vleft = int'($urandom_range(4, 20));
                else if (vph == 1) vleft = 2;
                else vleft = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 8))
                                                          : int'($urandom_range(14, 30));
            end
            vleft--;
            if (bleft == 0) begin
                bon = !bon;
                bleft = bon ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 25));
            end
            bleft--;
            lam = {vph == 2, vph == 1, vph == 0};
            if ($urandom_range(0, 79) == 0) lam = bad[$urandom_range(0, 4)];
            m_step(bon, lam[2], lam[1], lam[0]);
            cyc(bon, lam[2], lam[1], lam[0]);
            if (walk && countdown == 5'(WC - 1)) walks++;
            chk($sformatf("rand%0d", c), m_exp());
        end
        $display("seq random: 4000 cycles, %0d crossings started", walks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
